// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC and drives the combinational instruction memory.
// It registers fetched words into a valid/ready decode register, handles redirects and halts on an invalid fetch address.
module fetch_controller #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] mem_pc,
  input  logic [31:0] mem_instr,
  input  logic        mem_inv_addr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [63:0] dec_pc,
  output logic        fault,
  output logic [63:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        dec_valid_q, dec_valid_d;
  logic [31:0] dec_instr_q, dec_instr_d;
  logic [63:0] dec_pc_q, dec_pc_d;
  logic        fault_q, fault_d;
  logic [63:0] fault_pc_q, fault_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        load;
  logic        handshake;

  always_comb begin
    load          = !dec_valid_q || dec_ready;
    handshake     = dec_valid_q && dec_ready;
    state_d       = state_q;
    pc_d          = pc_q;
    dec_valid_d   = dec_valid_q;
    dec_instr_d   = dec_instr_q;
    dec_pc_d      = dec_pc_q;
    fault_d       = fault_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q;

    // The handshake is counted even when a redirect drops the next word.
    if (handshake) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

    if (redirect_valid) begin
      state_d     = RUN;
      pc_d        = redirect_pc;
      dec_valid_d = 1'b0;
      fault_d     = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (load) begin
            if (mem_inv_addr) begin
              state_d     = FAULT;
              fault_d     = 1'b1;
              fault_pc_d  = pc_q;
              dec_valid_d = 1'b0;
            end else begin
              dec_instr_d = mem_instr;
              dec_pc_d    = pc_q;
              dec_valid_d = 1'b1;
              pc_d        = pc_q + 64'd4;
            end
          end
        end
        FAULT: begin
          if (handshake) begin
            dec_valid_d = 1'b0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      dec_valid_q   <= 1'b0;
      dec_instr_q   <= '0;
      dec_pc_q      <= '0;
      fault_q       <= 1'b0;
      fault_pc_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      dec_valid_q   <= dec_valid_d;
      dec_instr_q   <= dec_instr_d;
      dec_pc_q      <= dec_pc_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign mem_pc      = pc_q;
  assign dec_valid   = dec_valid_q;
  assign dec_instr   = dec_instr_q;
  assign dec_pc      = dec_pc_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = fetch_count_q;

endmodule
